downcounter_tc: RTL

DOWNCOUNTER_TC -- requirements
Module: downcounter_tc

---
 rtl/downcounter_tc.sv | 90 +++++++++
 1 files changed

// File: rtl/downcounter_tc.sv
// Loadable down-counter with registered terminal-count strobe, one-shot
// or auto-reload operation, and a two-state IDLE/RUN control FSM.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous reset, active-low
//   load    in   parallel load strobe; also captures the reload value
//   preset  in   WIDTH-bit load / reload value
//   cen     in   count enable (cascade input)
//   mode    in   0 = one-shot, 1 = auto-reload
//   counter out  current count, registered
//   tc      out  terminal-count strobe, one clock per terminal event
//   busy    out  high while the FSM is in RUN
module downcounter_tc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] preset,
    input  logic             cen,
    input  logic             mode,
    output logic [WIDTH-1:0] counter,
    output logic             tc,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            count_q  <= ZERO;
            reload_q <= ZERO;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (load) begin
            count_d  = preset;
            reload_d = preset;
            state_d  = (preset != ZERO) ? RUN : IDLE;
        end else if (state_q == RUN && cen) begin
            unique case (1'b1)
                (count_q > ONE): begin
                    count_d = count_q - ONE;
                end
                (count_q == ONE): begin
                    count_d = ZERO;
                    tc_d    = 1'b1;
                    // mode only matters here; one-shot parks at zero
                    if (!mode) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    // RUN with zero count only occurs in auto-reload
                    count_d = reload_q;
                end
            endcase
        end
    end

    assign counter = count_q;
    assign tc      = tc_q;
    assign busy    = (state_q == RUN);

endmodule
